// File: rtl/wb_grf.sv
// Writeback-stage result mux plus 32x32 general register file.
// The final writeback value is combinational, so it can be committed on the
// next rising edge and forwarded to the read ports in the same cycle.
module wb_grf #(
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter logic [31:0] SP_INIT = 32'h0000_2ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_W,
  input  logic [31:0] DM_W,
  input  logic [31:0] EXT_W,
  input  logic [31:0] PC8_W,
  input  logic [4:0]  WBA_W,
  input  logic        we_W,
  input  logic [1:0]  wbsel_W,
  input  logic [2:0]  ldtype_W,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] wd_W,
  output logic [31:0] wcount
);

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  logic [31:0] r_rf [0:31];
  logic [31:0] r_wcount;
  logic [31:0] w_ld;
  logic [31:0] w_wd;
  logic        w_commit;

  // Extract and extend the addressed byte/half of the aligned memory word.
  // Unknown formats fall back to a full-word load.
  function automatic logic [31:0] load_extend(input logic [31:0] dm,
                                              input logic [1:0]  off,
                                              input logic [2:0]  ldtype);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = dm[7:0];
      2'd1:    b = dm[15:8];
      2'd2:    b = dm[23:16];
      default: b = dm[31:24];
    endcase
    h = off[1] ? dm[31:16] : dm[15:0];
    case (ldtype)
      LD_LB:   res = {{24{b[7]}}, b};
      LD_LBU:  res = {24'd0, b};
      LD_LH:   res = {{16{h[15]}}, h};
      LD_LHU:  res = {16'd0, h};
      default: res = dm;
    endcase
    return res;
  endfunction

  // Read port with $0 hardwired and same-cycle bypass of the pending write.
  function automatic logic [31:0] read_port(input logic [4:0]  ra,
                                            input logic [31:0] stored,
                                            input logic [31:0] wd,
                                            input logic        we,
                                            input logic [4:0]  wa);
    logic [31:0] res;
    if (ra == 5'd0)
      res = 32'd0;
    else if (we && (wa == ra))
      res = wd;
    else
      res = stored;
    return res;
  endfunction

  // Select the writeback result; load path formats the memory word first.
  always_comb begin
    w_ld = load_extend(DM_W, ALU_W[1:0], ldtype_W);
    w_wd = ALU_W;
    case (wbsel_W)
      2'd0:    w_wd = ALU_W;
      2'd1:    w_wd = w_ld;
      2'd2:    w_wd = EXT_W;
      default: w_wd = PC8_W;
    endcase
  end

  assign w_commit = we_W && (WBA_W != 5'd0);

  // Register file and commit counter; reset loads the gp/sp initial values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 28)
          r_rf[i] <= GP_INIT;
        else if (i == 29)
          r_rf[i] <= SP_INIT;
        else
          r_rf[i] <= 32'd0;
      end
      r_wcount <= 32'd0;
    end else if (w_commit) begin
      r_rf[WBA_W] <= w_wd;
      r_wcount    <= r_wcount + 32'd1;
    end
  end

  // Combinational read ports.
  always_comb begin
    rd1 = read_port(ra1, r_rf[ra1], w_wd, we_W, WBA_W);
    rd2 = read_port(ra2, r_rf[ra2], w_wd, we_W, WBA_W);
  end

  assign wd_W   = w_wd;
  assign wcount = r_wcount;

endmodule

// File: tb/tb_wb_grf.sv
module tb_wb_grf;

  logic        clk;
  logic        reset;
  logic [31:0] ALU_W, DM_W, EXT_W, PC8_W;
  logic [4:0]  WBA_W;
  logic        we_W;
  logic [1:0]  wbsel_W;
  logic [2:0]  ldtype_W;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, wd_W, wcount;

  int n_cmp;
  int n_fail;

  logic [31:0] model_rf [0:31];
  logic [31:0] model_cnt;

  wb_grf dut (
    .clk(clk), .reset(reset),
    .ALU_W(ALU_W), .DM_W(DM_W), .EXT_W(EXT_W), .PC8_W(PC8_W),
    .WBA_W(WBA_W), .we_W(we_W), .wbsel_W(wbsel_W), .ldtype_W(ldtype_W),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .wd_W(wd_W), .wcount(wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference load formatting, written with shifts and arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] dm,
                                           input logic [31:0] alu,
                                           input logic [2:0]  lt);
    logic [31:0] b, h;
    b = (dm >> (8 * alu[1:0])) & 32'hff;
    h = (dm >> (16 * alu[1])) & 32'hffff;
    case (lt)
      3'd1:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return h;
      default: return dm;
    endcase
  endfunction

  function automatic logic [31:0] ref_wd();
    case (wbsel_W)
      2'd0:    return ALU_W;
      2'd1:    return ref_load(DM_W, ALU_W, ldtype_W);
      2'd2:    return EXT_W;
      default: return PC8_W;
    endcase
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] ra);
    if (ra == 0) return 32'd0;
    if (we_W && WBA_W == ra) return ref_wd();
    return model_rf[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    model_rf[28] = 32'h0000_1800;
    model_rf[29] = 32'h0000_2ffc;
    model_cnt = 32'd0;
  endtask

  // Update the model for the pending write, then take one rising edge.
  task automatic commit();
    if (reset && we_W && WBA_W != 0) begin
      model_rf[WBA_W] = ref_wd();
      model_cnt = model_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_W = 0; DM_W = 0; EXT_W = 0; PC8_W = 0;
    WBA_W = 0; we_W = 0; wbsel_W = 0; ldtype_W = 0; ra1 = 0; ra2 = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    model_reset();
    ra1 = 5'd28; ra2 = 5'd29;
    @(posedge clk); #1;
    n_cmp++; if (rd1 !== 32'h1800) begin n_fail++; $display("FAIL reset_gp: got %h want %h", rd1, 32'h1800); end
    n_cmp++; if (rd2 !== 32'h2ffc) begin n_fail++; $display("FAIL reset_sp: got %h want %h", rd2, 32'h2ffc); end
    n_cmp++; if (wcount !== 32'd0) begin n_fail++; $display("FAIL reset_wcount: got %h want 0", wcount); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    ra1 = 5'd5; #1;
    n_cmp++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL reset_r5: got %h want 0", rd1); end
    n_cmp++; if (wcount !== 32'd0) begin n_fail++; $display("FAIL post_reset_wcount: got %h want 0", wcount); end
  endtask

  task automatic test_load();
    logic [31:0] exp_tab [4];
    logic [2:0]  lt_tab  [4];
    logic [31:0] off_tab [4];
    exp_tab = '{32'hffff_fff0, 32'h0000_0080, 32'hffff_8034, 32'h0000_56f0};
    lt_tab  = '{3'd1, 3'd2, 3'd3, 3'd4};
    off_tab = '{32'd0, 32'd3, 32'd2, 32'd0};
    idle_inputs();
    DM_W = 32'h8034_56f0; wbsel_W = 2'd1;
    for (int i = 0; i < 4; i++) begin
      ldtype_W = lt_tab[i]; ALU_W = off_tab[i]; #1;
      n_cmp++;
      if (wd_W !== exp_tab[i]) begin n_fail++; $display("FAIL load_dir%0d: got %h want %h", i, wd_W, exp_tab[i]); end
    end
    for (int i = 0; i < 60; i++) begin
      DM_W = $urandom; ALU_W = $urandom; EXT_W = $urandom; PC8_W = $urandom;
      wbsel_W = 2'($urandom_range(0, 3)); ldtype_W = 3'($urandom_range(0, 7)); #1;
      n_cmp++;
      if (wd_W !== ref_wd()) begin
        n_fail++;
        $display("FAIL load_rand sel=%0d lt=%0d: got %h want %h", wbsel_W, ldtype_W, wd_W, ref_wd());
      end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we_W = 1'b1; WBA_W = 5'd5; wbsel_W = 2'd3; PC8_W = 32'h3008; ra1 = 5'd5; ra2 = 5'd5; #1;
    n_cmp++; if (rd1 !== 32'h3008) begin n_fail++; $display("FAIL bypass_pre: got %h want %h", rd1, 32'h3008); end
    n_cmp++; if (rd2 !== rd1 || rd2 !== 32'h3008) begin n_fail++; $display("FAIL bypass_both: got %h want %h", rd2, 32'h3008); end
    commit();
    we_W = 1'b0; PC8_W = 32'h0; #1;
    n_cmp++; if (rd1 !== 32'h3008) begin n_fail++; $display("FAIL bypass_post: got %h want %h", rd1, 32'h3008); end
    n_cmp++; if (wcount !== model_cnt) begin n_fail++; $display("FAIL bypass_wcount: got %h want %h", wcount, model_cnt); end
  endtask

  task automatic test_zero_write();
    idle_inputs();
    we_W = 1'b1; WBA_W = 5'd0; wbsel_W = 2'd0; ALU_W = 32'hdead_beef; ra1 = 5'd0; #1;
    n_cmp++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL zero_pre: got %h want 0", rd1); end
    commit();
    n_cmp++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL zero_post: got %h want 0", rd1); end
    n_cmp++; if (wcount !== model_cnt) begin n_fail++; $display("FAIL zero_wcount: got %h want %h", wcount, model_cnt); end
    we_W = 1'b0; WBA_W = 5'd9; ALU_W = 32'h55; commit();
    n_cmp++; if (wcount !== model_cnt) begin n_fail++; $display("FAIL nowe_wcount: got %h want %h", wcount, model_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      DM_W = $urandom; ALU_W = $urandom; EXT_W = $urandom; PC8_W = $urandom;
      wbsel_W = 2'($urandom_range(0, 3)); ldtype_W = 3'($urandom_range(0, 7));
      we_W = 1'($urandom_range(0, 3) != 0);
      WBA_W = 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? WBA_W : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1   : 5'($urandom_range(0, 31));
      #1;
      n_cmp++;
      if (rd1 !== ref_rd(ra1)) begin n_fail++; $display("FAIL rand_rd1 ra=%0d: got %h want %h", ra1, rd1, ref_rd(ra1)); end
      n_cmp++;
      if (rd2 !== ref_rd(ra2)) begin n_fail++; $display("FAIL rand_rd2 ra=%0d: got %h want %h", ra2, rd2, ref_rd(ra2)); end
      commit();
      n_cmp++;
      if (wcount !== model_cnt) begin n_fail++; $display("FAIL rand_wcount: got %h want %h", wcount, model_cnt); end
    end
    idle_inputs();
    for (int r = 1; r < 32; r++) begin
      ra1 = 5'(r); #1;
      n_cmp++;
      if (rd1 !== model_rf[r]) begin n_fail++; $display("FAIL sweep r%0d: got %h want %h", r, rd1, model_rf[r]); end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    we_W = 1'b1; WBA_W = 5'd7; wbsel_W = 2'd0; ALU_W = 32'h1234; commit();
    we_W = 1'b0; ra1 = 5'd7; #1;
    n_cmp++; if (rd1 !== 32'h1234) begin n_fail++; $display("FAIL r7_written: got %h want %h", rd1, 32'h1234); end
    #1 reset = 1'b0; model_reset(); #1;
    n_cmp++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL r7_async_clear: got %h want 0", rd1); end
    we_W = 1'b1; WBA_W = 5'd9; ALU_W = 32'h77;
    @(posedge clk); #1; @(posedge clk); #1;
    n_cmp++; if (wcount !== 32'd0) begin n_fail++; $display("FAIL reset_edges_wcount: got %h want 0", wcount); end
    we_W = 1'b0; ra1 = 5'd9; ra2 = 5'd29; #1;
    n_cmp++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL reset_edges_r9: got %h want 0", rd1); end
    n_cmp++; if (rd2 !== 32'h2ffc) begin n_fail++; $display("FAIL reset_mid_sp: got %h want %h", rd2, 32'h2ffc); end
    reset = 1'b1;
    we_W = 1'b1; WBA_W = 5'd9; ALU_W = 32'h99; commit();
    we_W = 1'b0; #1;
    n_cmp++; if (rd1 !== 32'h99) begin n_fail++; $display("FAIL first_commit: got %h want %h", rd1, 32'h99); end
    n_cmp++; if (wcount !== 32'd1) begin n_fail++; $display("FAIL first_commit_wcount: got %h want 1", wcount); end
  endtask

  task automatic test_wrap();
    idle_inputs();
    @(negedge clk);
    force dut.r_wcount = 32'hffff_ffff;
    #1 release dut.r_wcount;
    #1;
    n_cmp++; if (wcount !== 32'hffff_ffff) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", wcount); end
    model_cnt = 32'hffff_ffff;
    we_W = 1'b1; WBA_W = 5'd3; wbsel_W = 2'd2; EXT_W = 32'habcd_0000; commit();
    n_cmp++; if (wcount !== 32'd0) begin n_fail++; $display("FAIL wrap: got %h want 0", wcount); end
    we_W = 1'b0; ra2 = 5'd3; #1;
    n_cmp++; if (rd2 !== 32'habcd_0000) begin n_fail++; $display("FAIL wrap_r3: got %h want %h", rd2, 32'habcd_0000); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_load();
    test_bypass();
    test_zero_write();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 Parameter GP_INIT, default 32'h0000_1800, reset value of register $28.
REQ-002 Parameter SP_INIT, default 32'h0000_2ffc, reset value of register $29.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low clears state immediately, regardless of clk.
REQ-005 ALU_W  input  32  ALU result from MEM/WB register; bits [1:0] are the load byte offset.
REQ-006 DM_W  input  32  raw aligned word read from data memory.
REQ-007 EXT_W  input  32  extended immediate (lui path).
REQ-008 PC8_W  input  32  link address (PC+8).
REQ-009 WBA_W  input  5  destination register number.
REQ-010 we_W  input  1  register write enable for the instruction in WB.
REQ-011 wbsel_W  input  2  result select: 0 ALU_W, 1 load data, 2 EXT_W, 3 PC8_W.
REQ-012 ldtype_W  input  3  load format: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5-7 treated as lw.
REQ-013 ra1, ra2  input  5 each  read addresses from decode stage.
REQ-014 rd1, rd2  output  32 each  read data for ra1/ra2.
REQ-015 wd_W  output  32  final writeback value (for forwarding to earlier stages).
REQ-016 wcount  output  32  count of committed register writes.

Function
REQ-017 Load data: lw passes DM_W; lb/lbu select byte ALU_W[1:0] (0 = bits 7:0, 3 = bits 31:24) then sign/zero extend; lh/lhu select half by ALU_W[1] (0 = bits 15:0) then sign/zero extend; ALU_W[0] ignored for halves.
REQ-018 wd_W is combinational from wbsel_W and the inputs; zero latency.
REQ-019 Register file: 32 x 32-bit; register 0 reads 0 always and is never written.
REQ-020 Commit: on rising clk with reset high, if we_W=1 and WBA_W!=0, register WBA_W <= wd_W.
REQ-021 Reads are combinational; rdN = 0 if raN=0; else wd_W if we_W=1 and WBA_W=raN (write-before-read bypass, same-cycle value visible); else stored value.
REQ-022 Both ports may read the same register, including the bypassed one; both return identical data.
REQ-023 wcount increments by 1 on each commit per REQ-020; writes to $0 or with we_W=0 do not count; wraps 32'hffff_ffff -> 0.
REQ-024 No other state; no stall or handshake; one write per cycle maximum.

Reset
REQ-025 While reset=0: all registers 0 except $28=GP_INIT and $29=SP_INIT; wcount=0; rd1/rd2 reflect these values (bypass still applies combinationally).
REQ-026 Reset assertion mid-cycle takes effect immediately; a rising clk during reset=0 commits nothing.
REQ-027 First commit occurs on the first rising clk after reset returns high.

Verification
REQ-028 Reset then ra1=28, ra2=29, we_W=0 -> rd1=32'h1800, rd2=32'h2ffc, wcount=0.
REQ-029 DM_W=32'h8034_56f0, wbsel=1: lb ALU_W[1:0]=0 -> wd_W=32'hffff_fff0; lbu offset 3 -> 32'h0000_0080; lh ALU_W=2 -> 32'hffff_8034; lhu ALU_W=0 -> 32'h0000_56f0.
REQ-030 we_W=1, WBA_W=5, wbsel=3, PC8_W=32'h3008, ra1=5 before edge -> rd1=32'h3008 pre-edge via bypass; after edge with we_W=0 -> rd1=32'h3008, wcount=1.
REQ-031 we_W=1, WBA_W=0, wbsel=0, ALU_W=32'hdead_beef, ra1=0 -> rd1=0 before and after edge; wcount unchanged.
REQ-032 Write $7=32'h1234 then drop reset low between edges -> rd for $7 reads 0 immediately; edges during reset leave wcount=0.
REQ-033 Preload wcount to 32'hffff_ffff via forced state, one commit -> wcount=0.
